// File: rtl/reg2uart_master.sv
// Host-side initiator for the UART register protocol: sends a 6-byte command
// frame, collects the 6-byte response and reports read data plus status.
`timescale 1ns/1ps

module reg2uart_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_txen,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_txempty
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;

  // 8N1, LSB first; shreg holds {stop, data, start} and shifts out bit 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx      <= 1'b1;
      o_txempty <= 1'b1;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
    end else if (o_txempty) begin
      if (i_txen) begin
        shreg     <= {1'b1, i_data, 1'b0};
        o_tx      <= 1'b0;
        o_txempty <= 1'b0;
        clk_cnt   <= '0;
        bit_cnt   <= '0;
      end
    end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        o_txempty <= 1'b1;
        o_tx      <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        o_tx    <= shreg[1];
        shreg   <= {1'b1, shreg[9:1]};
      end
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end
endmodule

module reg2uart_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_dataen
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [1:0]    sync;
  logic          active;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  // Start edge arms a half-bit delay so every later sample lands mid-bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync     <= 2'b11;
      active   <= 1'b0;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_data   <= '0;
      o_dataen <= 1'b0;
    end else begin
      sync     <= {sync[0], i_rx};
      o_dataen <= 1'b0;
      if (!active) begin
        if (!sync[1]) begin
          active  <= 1'b1;
          clk_cnt <= CW'(CLKS_PER_BIT / 2);
          bit_cnt <= '0;
        end
      end else if (clk_cnt != '0) begin
        clk_cnt <= clk_cnt - CW'(1);
      end else begin
        clk_cnt <= CW'(CLKS_PER_BIT - 1);
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd0) begin
          if (sync[1]) active <= 1'b0;
        end else if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          if (sync[1]) begin
            o_data   <= shreg;
            o_dataen <= 1'b1;
          end
        end else begin
          shreg <= {sync[1], shreg[7:1]};
        end
      end
    end
  end
endmodule

module reg2uart_master #(
  parameter int unsigned TIMEOUT_CYC  = 1000000,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_rdata
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_WAIT, S_TX_PULSE, S_TX_GAP, S_RX, S_DONE
  } state_t;

  state_t         state;
  logic [2:0]     byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic           wr_q;
  logic [15:0]    addr_q;
  logic [15:0]    wdata_q;
  logic [7:0]     rsp_status;
  logic [7:0]     rsp_hi;
  logic [7:0]     rsp_lo;
  logic           tx_en;
  logic           tx_empty;
  logic [7:0]     tx_byte;
  logic [7:0]     cmd_byte0;
  logic [7:0]     csum;
  logic [7:0]     rx_data;
  logic           rx_valid;

  reg2uart_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_txen    (tx_en),
    .i_data    (tx_byte),
    .o_tx      (o_uart_tx),
    .o_txempty (tx_empty)
  );

  reg2uart_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rx     (i_uart_rx),
    .o_data   (rx_data),
    .o_dataen (rx_valid)
  );

  assign tx_en     = (state == S_TX_PULSE);
  assign cmd_byte0 = {7'd0, wr_q};
  assign csum      = cmd_byte0 + addr_q[15:8] + addr_q[7:0] + wdata_q[15:8] + wdata_q[7:0];

  // Command frame byte selected by the byte counter
  always_comb begin
    tx_byte = 8'h00;
    case (byte_cnt)
      3'd0:    tx_byte = cmd_byte0;
      3'd1:    tx_byte = addr_q[15:8];
      3'd2:    tx_byte = addr_q[7:0];
      3'd3:    tx_byte = wdata_q[15:8];
      3'd4:    tx_byte = wdata_q[7:0];
      default: tx_byte = csum;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_status <= '0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            wr_q     <= i_wr;
            addr_q   <= i_addr;
            wdata_q  <= i_wr ? i_wdata : 16'h0000;
            byte_cnt <= '0;
            o_busy   <= 1'b1;
            state    <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: if (tx_empty) state <= S_TX_PULSE;
        S_TX_PULSE: state <= S_TX_GAP;
        S_TX_GAP: begin
          if (byte_cnt == 3'd5) begin
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= S_RX;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
            state    <= S_TX_WAIT;
          end
        end
        // A byte arriving on the expiry cycle wins over the timeout
        S_RX: begin
          if (rx_valid) begin
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 3'd1;
            case (byte_cnt)
              3'd0:    rsp_status <= rx_data;
              3'd1:    rsp_hi     <= rx_data;
              3'd2:    rsp_lo     <= rx_data;
              default: ;
            endcase
            if (byte_cnt == 3'd5) begin
              state  <= S_DONE;
              o_done <= 1'b1;
              o_err  <= (rsp_status != 8'hFF);
              if (rsp_status == 8'hFF) o_rdata <= {rsp_hi, rsp_lo};
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            o_err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          byte_cnt <= '0;
          o_busy   <= 1'b0;
          o_err    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
